uart_text_writer: RTL
=====================

# uart_text_writer

Cursor and command controller between the UART receiver and the character text-buffer RAM of the VGA text display. Consumes received bytes, interprets printable characters and a small set of control codes, and drives the RAM write port (row, column, data, enable) for the 32×4 character grid. Also performs a clear sweep after reset and on form-feed. Exports the live cursor position for display overlay.

## Interface
- COLS, 32, columns per row; power of two
- ROWS, 4, rows per screen; power of two
- CLEAR_CHAR, 8'h20, fill byte for clear and backspace erase
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-low reset
- rx_data  input  8  received byte; valid while rx_valid high
- rx_valid  input  1  level strobe from UART; may stay high for many cycles per byte
- wr_en  output  1  RAM write enable, one-cycle pulse per write
- wr_row  output  log2(ROWS)  RAM write row
- wr_col  output  log2(COLS)  RAM write column
- wr_data  output  8  RAM write data
- cur_row  output  log2(ROWS)  current cursor row
- cur_col  output  log2(COLS)  current cursor column
- busy  output  1  high while clear sweep runs
- overflow  output  1  sticky; byte dropped because pending slot was full

## Operation
- Byte acceptance: rising edge of rx_valid (high now, low previous cycle) is one byte event; rx_data captured into a one-entry pending slot. Holding rx_valid high produces no further events.
- Pending slot full when an event arrives: new byte dropped, overflow set. overflow cleared only by reset.
- FSM states: CLEAR, IDLE, EXEC.
  - CLEAR: writes CLEAR_CHAR to every cell, one per cycle, row-major from (0,0) to (ROWS-1,COLS-1); ROWS×COLS cycles; busy=1; then cursor=(0,0), go IDLE (or EXEC if slot full).
  - IDLE: slot full -> EXEC.
  - EXEC: decode slot byte, empty slot, return IDLE; one cycle.
- Byte decode in EXEC:
  - 0x20–0x7E: write byte at cursor, then advance col; col COLS-1 -> col 0, row+1; row ROWS-1 -> row 0 (wrap, no scroll).
  - 0x0D (CR): col=0; no write.
  - 0x0A (LF): row+1 with wrap; col unchanged; no write.
  - 0x08 (BS): col>0 -> col-1; col=0,row>0 -> row-1, col COLS-1; at (0,0) stays. Writes CLEAR_CHAR at the new position.
  - 0x0C (FF): enter CLEAR.
  - all other bytes (incl. 0x7F, ≥0x80): ignored, slot emptied, no write.
- Reset (reset=0 at an edge): enter CLEAR at the first edge with reset=1; slot empty, edge-detect history=1 (byte held across reset not accepted), overflow=0. Reset mid-sweep restarts the sweep from (0,0).

## Timing
- Reset values: wr_en=0, wr_row=0, wr_col=0, wr_data=0, cur_row=0, cur_col=0, busy=1, overflow=0.
- All outputs registered.
- Event at edge k (slot loaded); EXEC at edge k+1: wr_en high for the cycle after edge k+1 with wr_row/wr_col/wr_data of the write target; cur_row/cur_col updated at the same edge k+1.
- Sustained throughput: one byte per 2 cycles; UART rate (~1 byte / 10 µs) never saturates outside CLEAR.
- Event on the same edge EXEC empties the slot: slot reloaded with new byte, no drop.
- During CLEAR: one byte accepted into slot; second byte dropped with overflow. Slot byte executes the cycle after the last clear write.
- Clear sweep: wr_en high for exactly ROWS×COLS consecutive cycles; busy falls on the edge after the last write.

## Structure
- Package text_buf_pkg: COL_W, ROW_W, ASCII constants (CR, LF, BS, FF, printable bounds), FSM state encoding.
- Sub-module byte_edge_detect: rx_valid rising-edge pulse plus data capture; rest is one FSM module.

## Test plan
- Reset release -> 128 consecutive wr_en cycles writing 0x20 at (0,0)…(3,31); busy falls; cursor (0,0).
- "A" (0x41) with rx_valid held 50 cycles -> exactly one write (0,0)=0x41, cursor (0,1).
- 32 printable bytes, then 0x42 -> 32nd write at (0,31), 0x42 at (1,0); at (3,31) a write wraps cursor to (0,0).
- Cursor (1,0), 0x08 -> write 0x20 at (0,31), cursor (0,31); at (0,0) 0x08 -> write 0x20 at (0,0), cursor stays.
- 0x0C then 0x43 and 0x44 during sweep -> 128 clear writes, 0x43 at (0,0), 0x44 dropped, overflow=1.
- 0x0D, 0x0A, 0x07 at cursor (2,5) -> (2,0), (3,0), unchanged; no wr_en for any.

Source files
------------

// File: rtl/text_buf_pkg.sv
// text_buf_pkg: grid geometry, ASCII control codes and FSM states of the UART text writer (no ports)
package text_buf_pkg;
    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [7:0] CLEAR_CHAR = 8'h20;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;
    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_EXEC} state_t;
    function automatic logic is_printable(input logic [7:0] b);
        return b >= PRINT_LO && b <= PRINT_HI;
    endfunction
endpackage

// File: rtl/uart_text_writer_if.sv
// uart_text_writer_if: UART byte input, text RAM write port and status of the text writer
//   rx_data/rx_valid: received byte and level strobe
//   wr_en/wr_row/wr_col/wr_data: RAM write port; cur_row/cur_col: cursor; busy: clear sweep; overflow: dropped byte
interface uart_text_writer_if;
    import text_buf_pkg::*;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             busy;
    logic             overflow;
    modport master (input rx_data, rx_valid,
                    output wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy, overflow);
    modport slave  (output rx_data, rx_valid,
                    input wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy, overflow);
endinterface

// File: rtl/byte_edge_detect.sv
// byte_edge_detect: one-cycle byte event on the rising edge of rx_valid, with the byte alongside
//   clk, reset (sync, active-low); rx_valid, rx_data in; pulse, data out
module byte_edge_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       pulse,
    output logic [7:0] data
);
    logic prev;
    // History resets high so a byte still strobed across reset is not taken as new
    always_ff @(posedge clk) prev <= !reset ? 1'b1 : rx_valid;
    assign pulse = rx_valid & ~prev;
    assign data = rx_data;
endmodule

// File: rtl/uart_text_writer.sv
// uart_text_writer: turns received bytes into text RAM writes and cursor moves, with clear sweeps
//   clk, reset (sync, active-low); bus: uart_text_writer_if.master (rx in, RAM write/cursor/status out)
module uart_text_writer
    import text_buf_pkg::*;
(
    input logic               clk,
    input logic               reset,
    uart_text_writer_if.master bus
);
    logic ev;
    logic [7:0] ev_data;
    state_t state;
    logic slot_full;
    logic [7:0] slot;
    logic [ROW_W+COL_W-1:0] clr_idx;
    logic [ROW_W-1:0] bs_row;
    logic [COL_W-1:0] bs_col;

    byte_edge_detect u_edge (
        .clk(clk), .reset(reset), .rx_valid(bus.rx_valid), .rx_data(bus.rx_data),
        .pulse(ev), .data(ev_data)
    );

    // Backspace target: step left, wrap to the end of the previous row, pin at the origin
    always_comb begin
        bs_col = bus.cur_col != '0 ? bus.cur_col - 1'b1 : (bus.cur_row != '0 ? COL_W'(COLS - 1) : '0);
        bs_row = (bus.cur_col == '0 && bus.cur_row != '0) ? bus.cur_row - 1'b1 : bus.cur_row;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
            clr_idx <= '0;
            slot_full <= 1'b0;
            slot <= '0;
            bus.overflow <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.wr_row <= '0;
            bus.wr_col <= '0;
            bus.wr_data <= '0;
            bus.cur_row <= '0;
            bus.cur_col <= '0;
            bus.busy <= 1'b1;
        end else begin
            bus.wr_en <= 1'b0;
            bus.busy <= state == ST_CLEAR;
            // EXEC frees the slot on this edge, so a byte arriving now refills it instead of dropping
            if (ev) begin
                if (slot_full && state != ST_EXEC) bus.overflow <= 1'b1;
                else begin
                    slot_full <= 1'b1;
                    slot <= ev_data;
                end
            end else if (state == ST_EXEC) slot_full <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    bus.wr_en <= 1'b1;
                    {bus.wr_row, bus.wr_col} <= clr_idx;
                    bus.wr_data <= CLEAR_CHAR;
                    clr_idx <= clr_idx + 1'b1;
                    if (&clr_idx) begin
                        bus.cur_row <= '0;
                        bus.cur_col <= '0;
                        state <= (slot_full || ev) ? ST_EXEC : ST_IDLE;
                    end
                end
                ST_IDLE: if (slot_full || ev) state <= ST_EXEC;
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (is_printable(slot)) begin
                        bus.wr_en <= 1'b1;
                        bus.wr_row <= bus.cur_row;
                        bus.wr_col <= bus.cur_col;
                        bus.wr_data <= slot;
                        bus.cur_col <= bus.cur_col + 1'b1;
                        if (&bus.cur_col) bus.cur_row <= bus.cur_row + 1'b1;
                    end else if (slot == ASCII_CR) bus.cur_col <= '0;
                    else if (slot == ASCII_LF) bus.cur_row <= bus.cur_row + 1'b1;
                    else if (slot == ASCII_BS) begin
                        bus.wr_en <= 1'b1;
                        bus.wr_row <= bs_row;
                        bus.wr_col <= bs_col;
                        bus.wr_data <= CLEAR_CHAR;
                        bus.cur_row <= bs_row;
                        bus.cur_col <= bs_col;
                    end else if (slot == ASCII_FF) begin
                        state <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule
